// File: rtl/keccak_pkg.sv
// Shared types and helpers for the Keccak absorb buffer.
// Lane/byte views of the 1600-bit state, modes, FSM states, pad bytes.
package keccak_pkg;

  typedef logic [4:0][4:0][63:0] state_t;
  typedef logic [199:0][7:0] bytes_t;

  typedef enum logic [1:0] {
    SHA3_224,
    SHA3_256,
    SHA3_384,
    SHA3_512
  } mode_t;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    PAD_EMIT
  } fsm_t;

  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  function automatic logic [7:0] rate_bytes(mode_t m);
    logic [7:0] r;
    r = 8'd0;
    unique case (m)
      SHA3_224: r = 8'd144;
      SHA3_256: r = 8'd136;
      SHA3_384: r = 8'd104;
      SHA3_512: r = 8'd72;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keccak_absorb_buffer_if.sv
// Stream-in (AXI-Stream subset) and block-out handshake bundles.
// axis: TVALID/TREADY/TDATA/TKEEP/TLAST/TID; blk: valid/ready/state/last/mode.
interface keccak_axis_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                    TVALID;
  logic                    TREADY;
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic                    TLAST;
  logic [1:0]              TID;

  modport master (
    output TVALID, TDATA, TKEEP, TLAST, TID,
    input  TREADY
  );

  modport slave (
    input  TVALID, TDATA, TKEEP, TLAST, TID,
    output TREADY
  );
endinterface

interface keccak_blk_if ();
  import keccak_pkg::*;

  logic   blk_valid;
  logic   blk_ready;
  state_t blk_state;
  logic   blk_last;
  mode_t  blk_mode;

  modport master (
    output blk_valid, blk_state, blk_last, blk_mode,
    input  blk_ready
  );

  modport slave (
    input  blk_valid, blk_state, blk_last, blk_mode,
    output blk_ready
  );
endinterface

// File: rtl/keccak_pad_insert.sv
// Pure combinational SHA3 pad: byte end_idx ^= 0x06, byte rate-1 ^= 0x80.
// Ports: buf_i in, end_idx (ignored if >= rate), rate, buf_o padded out.
module keccak_pad_insert
  import keccak_pkg::*;
(
  input  state_t     buf_i,
  input  logic [7:0] end_idx,
  input  logic [7:0] rate,
  output state_t     buf_o
);

  bytes_t pb;

  always_comb begin
    pb = buf_i;
    if (end_idx < rate) begin
      pb[end_idx] = pb[end_idx] ^ PAD_FIRST;
    end
    pb[rate - 8'd1] = pb[rate - 8'd1] ^ PAD_LAST;
    buf_o = pb;
  end

endmodule

// File: rtl/keccak_absorb_buffer.sv
// Collects stream bytes into rate-sized SHA3 blocks with padding.
// Ports: ACLK, ARESETn (sync, low), s_axis slave, blk master, proto_err.
module keccak_absorb_buffer
  import keccak_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  keccak_axis_if.slave s_axis,
  keccak_blk_if.master blk,
  output logic         proto_err
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  fsm_t   state_q, state_d;
  bytes_t buf_q, buf_d, wr_buf;
  state_t pad_in, pad_out;
  logic [7:0] pad_end;
  logic [7:0] cnt_q, cnt_d;
  mode_t  mode_q, mode_d, cur_mode;
  logic   open_q, open_d;
  logic   pend_q, pend_d;
  logic   last_q, last_d;
  logic   valid_q, tready_q;
  logic   perr_q, perr_d;
  logic   acc, first, hs;
  logic [7:0] rate, pop;
  logic [8:0] new_cnt, wr_idx;
  logic [KEEP_WIDTH-1:0] keep_inc;
  logic   keep_gap, keep_part;

  assign acc   = s_axis.TVALID & tready_q;
  assign hs    = valid_q & blk.blk_ready;
  // Mode only comes from TID when no message is open.
  assign first = (state_q == FILL) && (cnt_q == 8'd0) && !open_q;
  assign cur_mode = first ? mode_t'(s_axis.TID) : mode_q;
  assign rate  = rate_bytes(cur_mode);

  // Contiguous-from-bit-0 masks have no set bit shared with mask+1.
  assign keep_inc  = s_axis.TKEEP + KEEP_WIDTH'(1);
  assign keep_gap  = |(s_axis.TKEEP & keep_inc);
  assign keep_part = ~&s_axis.TKEEP;

  always_comb begin
    pop = 8'd0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      pop = pop + {7'd0, s_axis.TKEEP[i]};
    end
  end

  assign new_cnt = {1'b0, cnt_q} + {1'b0, pop};

  // Lowest popcount bytes of the beat land at the counter position.
  always_comb begin
    wr_buf = buf_q;
    wr_idx = 9'd0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      wr_idx = {1'b0, cnt_q} + 9'(i);
      if ((8'(i) < pop) && (wr_idx < {1'b0, rate})) begin
        wr_buf[wr_idx[7:0]] = s_axis.TDATA[8*i +: 8];
      end
    end
  end

  // In EMIT the pad unit builds the pad-only block from an empty buffer.
  assign pad_in  = (state_q == EMIT) ? '0 : wr_buf;
  assign pad_end = (state_q == EMIT) ? 8'd0 : new_cnt[7:0];

  keccak_pad_insert u_pad (
    .buf_i   (pad_in),
    .end_idx (pad_end),
    .rate    (rate),
    .buf_o   (pad_out)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    open_d  = open_q;
    pend_d  = pend_q;
    last_d  = last_q;
    perr_d  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          mode_d = cur_mode;
          perr_d = keep_gap | (~s_axis.TLAST & keep_part);
          if (s_axis.TLAST) begin
            open_d  = 1'b0;
            cnt_d   = 8'd0;
            state_d = EMIT;
            if (new_cnt < {1'b0, rate}) begin
              buf_d  = pad_out;
              last_d = 1'b1;
            end else begin
              buf_d  = wr_buf;
              last_d = 1'b0;
              pend_d = 1'b1;
            end
          end else begin
            open_d = 1'b1;
            buf_d  = wr_buf;
            if (new_cnt >= {1'b0, rate}) begin
              cnt_d   = 8'd0;
              last_d  = 1'b0;
              state_d = EMIT;
            end else begin
              cnt_d = new_cnt[7:0];
            end
          end
        end
      end
      EMIT: begin
        if (hs) begin
          cnt_d = 8'd0;
          if (pend_q) begin
            buf_d   = pad_out;
            last_d  = 1'b1;
            pend_d  = 1'b0;
            state_d = PAD_EMIT;
          end else begin
            buf_d   = '0;
            last_d  = 1'b0;
            state_d = FILL;
          end
        end
      end
      PAD_EMIT: begin
        if (hs) begin
          buf_d   = '0;
          last_d  = 1'b0;
          open_d  = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q  <= FILL;
      buf_q    <= '0;
      cnt_q    <= 8'd0;
      mode_q   <= SHA3_224;
      open_q   <= 1'b0;
      pend_q   <= 1'b0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      tready_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      open_q   <= open_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      valid_q  <= (state_d != FILL);
      tready_q <= (state_d == FILL);
      perr_q   <= perr_d;
    end
  end

  assign s_axis.TREADY = tready_q;
  assign blk.blk_valid = valid_q;
  assign blk.blk_state = buf_q;
  assign blk.blk_last  = last_q;
  assign blk.blk_mode  = mode_q;
  assign proto_err     = perr_q;

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// Scoreboard bench for keccak_absorb_buffer (64-bit beats).
// Stimulus pushes expected blocks; a monitor pops them on each handshake.
module tb_keccak_absorb_buffer;
  import keccak_pkg::*;

  typedef struct {
    logic [1599:0] st;
    logic          last;
    logic [1:0]    mode;
  } exp_t;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic proto_err;

  always #5 ACLK = ~ACLK;

  keccak_axis_if #(.DATA_WIDTH(64)) ax ();
  keccak_blk_if bk ();

  keccak_absorb_buffer #(.DATA_WIDTH(64)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .s_axis    (ax),
    .blk       (bk),
    .proto_err (proto_err)
  );

  exp_t exp_q[$];
  logic [7:0] msg[$];
  int n_tests = 0;
  int n_fail = 0;
  int perr_seen = 0;
  int perr_exp = 0;
  int rates[4] = '{144, 136, 104, 72};

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int bad;
    forever begin
      @(negedge ACLK);
      if (ARESETn && proto_err) perr_seen++;
      if (ARESETn && bk.blk_valid && bk.blk_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_block: got last=%0b mode=%0d want none",
                   bk.blk_last, bk.blk_mode);
        end else begin
          e = exp_q.pop_front();
          if (bk.blk_state !== e.st || bk.blk_last !== e.last ||
              bk.blk_mode !== mode_t'(e.mode)) begin
            n_fail++;
            bad = 0;
            for (int k = 199; k >= 0; k--)
              if (bk.blk_state[8*k +: 8] !== e.st[8*k +: 8]) bad = k;
            $display("FAIL block: got last=%0b mode=%0d byte%0d=%0h want last=%0b mode=%0d byte%0d=%0h",
                     bk.blk_last, bk.blk_mode, bad, bk.blk_state[8*bad +: 8],
                     e.last, e.mode, bad, e.st[8*bad +: 8]);
          end
        end
      end
    end
  endtask

  task automatic push_hand(input int b0, input logic [7:0] v0,
                           input int b1, input logic [7:0] v1,
                           input int b2, input logic [7:0] v2,
                           input int b3, input logic [7:0] v3,
                           input logic [1:0] mode);
    exp_t e;
    e.st = '0;
    e.st[8*b0 +: 8] = v0;
    e.st[8*b1 +: 8] = v1;
    e.st[8*b2 +: 8] = v2;
    e.st[8*b3 +: 8] = v3;
    e.last = 1'b1;
    e.mode = mode;
    exp_q.push_back(e);
  endtask

  task automatic push_model(input logic [1:0] mode);
    exp_t e;
    int r, len, nb, idx;
    r = rates[mode];
    len = msg.size();
    nb = len / r + 1;
    for (int b = 0; b < nb; b++) begin
      e.st = '0;
      for (int k = 0; k < r; k++) begin
        idx = b * r + k;
        if (idx < len) e.st[8*k +: 8] = msg[idx];
      end
      if (b == nb - 1) begin
        e.st[8*(len - b*r) +: 8] = e.st[8*(len - b*r) +: 8] ^ 8'h06;
        e.st[8*(r-1) +: 8] = e.st[8*(r-1) +: 8] ^ 8'h80;
      end
      e.last = (b == nb - 1);
      e.mode = mode;
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_msg(input int len, input int seed);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'((i * 13 + seed) & 255));
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic l, input logic [1:0] id);
    int t;
    ax.TVALID = 1'b1;
    ax.TDATA = d;
    ax.TKEEP = k;
    ax.TLAST = l;
    ax.TID = id;
    t = 0;
    do begin
      @(negedge ACLK);
      t++;
    end while (!ax.TREADY && t < 400);
    if (!ax.TREADY) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: got TREADY=0 want 1");
    end
    @(posedge ACLK);
    #1;
    ax.TVALID = 1'b0;
  endtask

  task automatic send_msg(input logic [1:0] mode);
    logic [63:0] d;
    logic [7:0] k;
    int len, nbeats;
    len = msg.size();
    nbeats = (len == 0) ? 1 : (len + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 8; j++) begin
        if (b * 8 + j < len) begin
          d[8*j +: 8] = msg[b*8 + j];
          k[j] = 1'b1;
        end
      end
      send_beat(d, k, b == nbeats - 1, mode);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge ACLK);
      t++;
    end
    #1;
    chk(exp_q.size() == 0, name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic stall();
    int t;
    t = 0;
    while (!bk.blk_valid && t < 400) begin
      @(negedge ACLK);
      t++;
    end
    chk(bk.blk_valid === 1'b1, "stall_valid", 64'(bk.blk_valid), 64'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      chk(ax.TREADY === 1'b0, "stall_tready", 64'(ax.TREADY), 64'd0);
      chk(exp_q.size() > 0 && bk.blk_state === exp_q[0].st, "stall_state",
          bk.blk_state[63:0], (exp_q.size() > 0) ? exp_q[0].st[63:0] : 64'd0);
    end
    @(posedge ACLK);
    #1;
    bk.blk_ready = 1'b1;
  endtask

  initial begin
    ax.TVALID = 1'b0;
    ax.TDATA = '0;
    ax.TKEEP = '0;
    ax.TLAST = 1'b0;
    ax.TID = 2'd0;
    bk.blk_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk(ax.TREADY === 1'b0, "rst_tready", 64'(ax.TREADY), 64'd0);
    chk(bk.blk_valid === 1'b0, "rst_valid", 64'(bk.blk_valid), 64'd0);
    chk(bk.blk_last === 1'b0 && bk.blk_mode === SHA3_224 && proto_err === 1'b0,
        "rst_flags", {61'd0, bk.blk_last, bk.blk_mode}, 64'd0);
    chk(bk.blk_state === '0, "rst_state", bk.blk_state[63:0], 64'd0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;

    // empty SHA3-256 message
    push_hand(0, 8'h06, 135, 8'h80, 0, 8'h06, 135, 8'h80, 2'd1);
    send_beat(64'd0, 8'h00, 1'b1, 2'd1);
    drain("t1_empty256");

    // "abc"
    push_hand(0, 8'h61, 1, 8'h62, 2, 8'h63, 3, 8'h06, 2'd1);
    exp_q[exp_q.size()-1].st[8*135 +: 8] = 8'h80;
    send_beat(64'h636261, 8'h07, 1'b1, 2'd1);
    drain("t2_abc");

    // exact rate boundary -> data block then pad-only block
    fill_msg(136, 5);
    push_model(2'd1);
    send_msg(2'd1);
    drain("t3_boundary");

    // 143 bytes SHA3-224 -> 0x86 at byte 143
    fill_msg(143, 9);
    push_model(2'd0);
    send_msg(2'd0);
    drain("t4_x86");

    // backpressure during multi-block SHA3-512
    fill_msg(200, 3);
    push_model(2'd3);
    bk.blk_ready = 1'b0;
    fork
      send_msg(2'd3);
      stall();
    join
    drain("t5_stall");

    // reset mid-message discards partial SHA3-384 block
    for (int b = 0; b < 5; b++)
      send_beat({8{8'(b + 1)}}, 8'hFF, 1'b0, 2'd2);
    ARESETn = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk(ax.TREADY === 1'b0, "mid_rst_tready", 64'(ax.TREADY), 64'd0);
    chk(bk.blk_valid === 1'b0, "mid_rst_valid", 64'(bk.blk_valid), 64'd0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    push_hand(0, 8'h06, 71, 8'h80, 0, 8'h06, 71, 8'h80, 2'd3);
    send_beat(64'd0, 8'h00, 1'b1, 2'd3);
    drain("t6_empty512");

    // non-contiguous TKEEP: two bytes written, proto_err pulses
    push_hand(0, 8'h11, 1, 8'h55, 2, 8'h06, 135, 8'h80, 2'd1);
    perr_exp = 1;
    send_beat(64'h0000_0000_0055_5511, 8'h05, 1'b1, 2'd1);
    drain("t6_noncontig");
    repeat (3) @(posedge ACLK);
    #1;
    chk(perr_seen == perr_exp, "proto_err_count", 64'(perr_seen), 64'(perr_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
